// File: rtl/rvsp_ctrl_pkg.sv
// Shared encodings for the RVSP multi-cycle control unit: ALU codes, opcodes,
// FSM states and instruction classes.
package rvsp_ctrl_pkg;

  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_SRA = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b1000;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LW, C_SW, C_BR, C_ILL
  } iclass_t;

  // Opcode-only classification; funct3 legality is checked by alu_op_decode.
  function automatic iclass_t classify(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_R:      return C_R;
      OP_IALU:   return C_IALU;
      OP_LOAD:   return C_LW;
      OP_STORE:  return C_SW;
      OP_BRANCH: return C_BR;
      default:   return C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation select and legality check from class and funct fields.
module alu_op_decode
  import rvsp_ctrl_pkg::*;
(
  input  iclass_t              cls,
  input  logic [FUNCT3_W-1:0]  funct3,
  input  logic                 funct7b5,
  output logic [ALUOP_W-1:0]   aluop,
  output logic                 legal
);

  always_comb begin
    aluop = ALU_ADD;
    legal = 1'b0;
    case (cls)
      C_R, C_IALU: begin
        legal = 1'b1;
        case (funct3)
          3'b000: aluop = (cls == C_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: aluop = ALU_SLL;
          3'b010: aluop = ALU_SLT;
          3'b100: aluop = ALU_XOR;
          3'b101: aluop = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: aluop = ALU_OR;
          3'b111: aluop = ALU_AND;
          default: legal = 1'b0;  // unsigned compare has no ALU code
        endcase
      end
      C_LW, C_SW: legal = (funct3 == 3'b010);
      C_BR: begin
        aluop = ALU_SUB;
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/unid_controle_mc.sv
// Multi-cycle control unit for the RVSP datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing, one-cycle write strobes, memory handshake and illegal-opcode trap.
module unid_controle_mc
  import rvsp_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                funct7b5,
  input  logic                zero,
  input  logic                neg,
  input  logic                mem_ready,
  output logic                ir_we,
  output logic                pc_we,
  output logic                regWrite,
  output logic                ALUSrc,
  output logic                SeltipoSouB,
  output logic                MemToReg,
  output logic                MemWrite,
  output logic                PCSrc,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                illegal
);

  state_t  state_q;
  iclass_t class_q;
  logic    illegal_q;

  iclass_t             class_dec;
  iclass_t             dec_cls;
  logic [ALUOP_W-1:0]  dec_aluop;
  logic                dec_legal;
  logic                taken;
  logic                imm_src;

  assign class_dec = classify(opcode);
  // In DECODE the class register is not loaded yet, so check the live opcode.
  assign dec_cls   = (state_q == S_DECODE) ? class_dec : class_q;

  alu_op_decode u_alu_op_decode (
    .cls      (dec_cls),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .aluop    (dec_aluop),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      class_q   <= C_R;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          class_q <= class_dec;
          if (!dec_legal) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (class_q)
            C_BR:       state_q <= S_FETCH;
            C_LW, C_SW: state_q <= S_MEM;
            default:    state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) state_q <= (class_q == C_SW) ? S_FETCH : S_WB;
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = neg;
      3'b101:  taken = !neg;
      default: taken = 1'b0;
    endcase
  end

  assign imm_src = (class_q == C_IALU) || (class_q == C_LW) || (class_q == C_SW);

  // Control outputs decoded from state and class register.
  always_comb begin
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    regWrite    = 1'b0;
    ALUSrc      = 1'b0;
    SeltipoSouB = 1'b0;
    MemToReg    = 1'b0;
    MemWrite    = 1'b0;
    PCSrc       = 1'b0;
    ALUOp       = ALU_ADD;
    case (state_q)
      S_FETCH: ir_we = 1'b1;
      S_EXEC: begin
        ALUOp  = dec_aluop;
        ALUSrc = imm_src;
        if (class_q == C_BR) begin
          SeltipoSouB = 1'b1;
          pc_we       = 1'b1;
          PCSrc       = taken;
        end
      end
      S_MEM: begin
        ALUOp    = ALU_ADD;
        ALUSrc   = 1'b1;
        MemWrite = (class_q == C_SW);
        pc_we    = (class_q == C_SW) && mem_ready;
      end
      S_WB: begin
        ALUOp    = dec_aluop;
        ALUSrc   = imm_src;
        regWrite = 1'b1;
        MemToReg = (class_q == C_LW);
        pc_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_unid_controle_mc.sv
// Scoreboard bench for unid_controle_mc: per-cycle expected controls derived
// from instruction-level timing rules, checked by an independent monitor.
module tb_unid_controle_mc;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic       reg_write;
    logic       alu_src;
    logic       sel_b;
    logic       mem_to_reg;
    logic       mem_write;
    logic       pc_src;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_we, pc_we, regWrite, ALUSrc, SeltipoSouB, MemToReg, MemWrite, PCSrc, illegal;
  logic [3:0] ALUOp;

  ctrl_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  unid_controle_mc dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we),
    .regWrite(regWrite), .ALUSrc(ALUSrc), .SeltipoSouB(SeltipoSouB), .MemToReg(MemToReg),
    .MemWrite(MemWrite), .PCSrc(PCSrc), .ALUOp(ALUOp), .illegal(illegal)
  );

  // Instruction class: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 BRANCH, 5 unknown opcode.
  function automatic int cls_of(input logic [31:0] i);
    case (i[6:0])
      7'h33:   return 0;
      7'h13:   return 1;
      7'h03:   return 2;
      7'h23:   return 3;
      7'h63:   return 4;
      default: return 5;
    endcase
  endfunction

  function automatic bit is_legal(input logic [31:0] i);
    int c;
    c = cls_of(i);
    if (c <= 1) return i[14:12] != 3'd3;
    if (c <= 3) return i[14:12] == 3'd2;
    if (c == 4) return i[14:12] inside {3'd0, 3'd1, 3'd4, 3'd5};
    return 1'b0;
  endfunction

  // add sll slt - xor srl or and, with sub/sra selected by inst[30].
  function automatic logic [3:0] ref_alu(input logic [31:0] i);
    int c;
    c = cls_of(i);
    if (c == 4) return 4'd1;
    if (c == 2 || c == 3) return 4'd0;
    case (i[14:12])
      3'd0:    return (c == 0 && i[30]) ? 4'd1 : 4'd0;
      3'd1:    return 4'd5;
      3'd2:    return 4'd8;
      3'd4:    return 4'd4;
      3'd5:    return i[30] ? 4'd7 : 4'd6;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [31:0] i, input bit z, input bit n);
    case (i[14:12])
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return n;
      3'd5:    return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle's inputs, queue its expected controls, advance to posedge+1.
  task automatic cyc(input ctrl_t e, input logic [31:0] i, input bit z, input bit n, input bit mr);
    opcode    = i[6:0];
    funct3    = i[14:12];
    funct7b5  = i[30];
    zero      = z;
    neg       = n;
    mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic ctrl_t reset_vec();
    ctrl_t e;
    e = '0;
    e.ir_we = 1'b1;
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(reset_vec(), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    rst_n = 1'b1;
  endtask

  // One instruction; w = mem_ready low cycles in MEM; rst_at = MEM cycle to reset in (-1 none).
  task automatic run_instr(input logic [31:0] i, input bit z, input bit n, input int w, input int rst_at);
    ctrl_t e;
    int    c;
    c = cls_of(i);
    e = '0;
    e.ir_we = 1'b1;
    cyc(e, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    e = '0;
    cyc(e, i, 1'($urandom), 1'($urandom), 1'($urandom));
    if (!is_legal(i)) begin
      for (int k = 0; k < 10; k++) begin
        e = '0;
        e.illegal = 1'b1;
        cyc(e, i, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      do_reset();
      return;
    end
    e = '0;
    e.alu_op  = ref_alu(i);
    e.alu_src = (c >= 1 && c <= 3);
    if (c == 4) begin
      e.sel_b  = 1'b1;
      e.pc_we  = 1'b1;
      e.pc_src = ref_taken(i, z, n);
      cyc(e, i, z, n, 1'($urandom));
      return;
    end
    cyc(e, i, 1'($urandom), 1'($urandom), 1'($urandom));
    if (c == 2 || c == 3) begin
      for (int k = 0; k <= w; k++) begin
        if (k == rst_at) begin
          rst_n = 1'b0;
          cyc(reset_vec(), i, 1'($urandom), 1'($urandom), 1'b0);
          rst_n = 1'b1;
          return;
        end
        e = '0;
        e.alu_op    = 4'd0;
        e.alu_src   = 1'b1;
        e.mem_write = (c == 3);
        e.pc_we     = (c == 3) && (k == w);
        cyc(e, i, 1'($urandom), 1'($urandom), k == w);
      end
      if (c == 3) return;
    end
    e = '0;
    e.reg_write  = 1'b1;
    e.pc_we      = 1'b1;
    e.mem_to_reg = (c == 2);
    e.alu_op     = ref_alu(i);
    e.alu_src    = (c >= 1 && c <= 3);
    cyc(e, i, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    int          c;
    i = $urandom;
    c = int'($urandom_range(0, 5));
    case (c)
      0: i[6:0] = 7'h33;
      1: i[6:0] = 7'h13;
      2: i[6:0] = 7'h03;
      3: i[6:0] = 7'h23;
      4: i[6:0] = 7'h63;
      default: i[6:0] = 7'h7F;
    endcase
    if ((c == 2 || c == 3) && $urandom_range(0, 9) != 0) i[14:12] = 3'd2;
    return i;
  endfunction

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    ctrl_t e, got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {ir_we, pc_we, regWrite, ALUSrc, SeltipoSouB, MemToReg, MemWrite, PCSrc, ALUOp, illegal};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL ctrl vec %0d t=%0t got=%b required=%b (ir pc rw src selb m2r mw pcsrc aluop ill)",
                 n_vec, $time, got, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ri;
    @(posedge clk);
    #1;
    cyc(reset_vec(), 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_instr(32'h00208093, 1'b0, 1'b0, 0, -1);  // addi
    run_instr(32'h40208033, 1'b0, 1'b0, 0, -1);  // sub
    run_instr(32'h0020A023, 1'b0, 1'b0, 3, -1);  // sw, 3 wait cycles
    run_instr(32'h0000A083, 1'b0, 1'b0, 0, -1);  // lw
    run_instr(32'h00000463, 1'b1, 1'b0, 0, -1);  // beq taken
    run_instr(32'h00000463, 1'b0, 1'b1, 0, -1);  // beq not taken
    run_instr(32'h00004463, 1'b0, 1'b1, 0, -1);  // blt taken
    run_instr(32'h00005463, 1'b0, 1'b1, 0, -1);  // bge not taken
    run_instr(32'h0000007F, 1'b0, 1'b0, 0, -1);  // illegal opcode -> trap
    run_instr(32'h0020A023, 1'b0, 1'b0, 5, 2);   // reset mid-MEM of sw
    run_instr(32'h0000A083, 1'b0, 1'b0, 2, -1);  // lw with waits
    for (int k = 0; k < 300; k++) begin
      ri = rand_instr();
      run_instr(ri, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
